// File: rtl/mem_channel_interface.sv
//==============================================================================
// Module      : mem_channel_interface
// Description : Multi-channel word-addressed storage. Requesters arbitrate
//               round-robin for a single shared port that accepts one access
//               per cycle. Reads are fully pipelined and return on a shared
//               rdata bus after RD_LATENCY cycles.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports:
//   clk     in   sole clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   req     in   [NUM_CH]              per-channel access request
//   we      in   [NUM_CH]              per-channel write enable (1 = write)
//   addr    in   [NUM_CH*ADDR_WIDTH]   per-channel byte address
//   wdata   in   [NUM_CH*DATA_WIDTH]   per-channel write data
//   wstrb   in   [NUM_CH*DATA_WIDTH/8] per-channel byte strobes
//   gnt     out  [NUM_CH]              one-hot grant (combinational)
//   rvalid  out  [NUM_CH]              one-hot read-data-valid (registered)
//   rdata   out  [DATA_WIDTH]          shared read data (registered)
//   busy    out                        a read is in flight in the pipeline
// Configuration macro:
//   MEMIF_BYTE_STROBE_EN - when defined, writes update only strobed bytes;
//                          otherwise wstrb is ignored and whole words written.
//==============================================================================
`default_nettype none

module mem_channel_interface #(
   parameter int NUM_CH     = 2,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int NUM_WORDS  = 128,
   parameter int RD_LATENCY = 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_CH-1:0]                req,
   input  logic [NUM_CH-1:0]                we,
   input  logic [NUM_CH*ADDR_WIDTH-1:0]     addr,
   input  logic [NUM_CH*DATA_WIDTH-1:0]     wdata,
   input  logic [NUM_CH*(DATA_WIDTH/8)-1:0] wstrb,
   output logic [NUM_CH-1:0]                gnt,
   output logic [NUM_CH-1:0]                rvalid,
   output logic [DATA_WIDTH-1:0]            rdata,
   output logic                             busy
);

   localparam int c_STRB_W = DATA_WIDTH / 8;
   localparam int c_PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int c_IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

   logic [c_PTR_W-1:0]    r_ptr;
   logic [c_PTR_W-1:0]    w_sel;
   logic [c_PTR_W-1:0]    w_cand;
   logic [c_PTR_W-1:0]    w_ptr_nxt;
   logic [NUM_CH-1:0]     w_gnt;
   logic                  w_any;

   logic                  w_we;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic [c_STRB_W-1:0]   w_wstrb;
   logic [c_IDX_W-1:0]    w_idx;
   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic                  w_busy;

   // Storage is deliberately left out of reset so contents survive it.
   logic [DATA_WIDTH-1:0] r_mem [NUM_WORDS];

   // Read pipeline: per-stage one-hot channel tag (all-zero = bubble) and data.
   // The last stage drives rvalid/rdata directly.
   logic [NUM_CH-1:0]     r_pipe_ch [RD_LATENCY];
   logic [DATA_WIDTH-1:0] r_pipe_d  [RD_LATENCY];

   // Round-robin search starting at the pointer, ascending with wrap.
   always_comb begin
      w_gnt  = '0;
      w_sel  = '0;
      w_cand = '0;
      w_any  = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         w_cand = c_PTR_W'((int'(r_ptr) + k) % NUM_CH);
         if (!w_any && req[w_cand]) begin
            w_any = 1'b1;
            w_sel = w_cand;
         end
      end
      // No grant may be issued while held in reset.
      if (!rst_n) begin
         w_any = 1'b0;
      end
      if (w_any) begin
         w_gnt[w_sel] = 1'b1;
      end
      w_ptr_nxt = c_PTR_W'((int'(w_sel) + 1) % NUM_CH);
   end

   assign gnt = w_gnt;

   // Steer the granted channel's request fields onto the shared port.
   always_comb begin
      w_we    = we[w_sel];
      w_addr  = addr[int'(w_sel)*ADDR_WIDTH +: ADDR_WIDTH];
      w_wdata = wdata[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH];
      w_wstrb = wstrb[int'(w_sel)*c_STRB_W +: c_STRB_W];
   end

   // Word index: byte address >> 2, upper bits dropped (wrap-around).
   assign w_idx    = c_IDX_W'(w_addr >> 2);
   assign w_wr_acc = w_any & w_we;
   assign w_rd_acc = w_any & ~w_we;

   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
`ifdef MEMIF_BYTE_STROBE_EN
         for (int b = 0; b < c_STRB_W; b++) begin
            if (w_wstrb[b]) begin
               r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
            end
         end
`else
         r_mem[w_idx] <= w_wdata;
`endif
      end
   end

   // Arbiter pointer and read pipeline. Memory is sampled on the accepting
   // edge, so any write committed on an earlier edge is already visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
         for (int k = 0; k < RD_LATENCY; k++) begin
            r_pipe_ch[k] <= '0;
            r_pipe_d[k]  <= '0;
         end
      end else begin
         if (w_any) begin
            r_ptr <= w_ptr_nxt;
         end
         r_pipe_ch[0] <= w_rd_acc ? w_gnt : '0;
         if (w_rd_acc) begin
            r_pipe_d[0] <= r_mem[w_idx];
         end
         // Data only advances with a valid read so rdata holds between reads.
         for (int k = 1; k < RD_LATENCY; k++) begin
            r_pipe_ch[k] <= r_pipe_ch[k-1];
            if (|r_pipe_ch[k-1]) begin
               r_pipe_d[k] <= r_pipe_d[k-1];
            end
         end
      end
   end

   always_comb begin
      w_busy = 1'b0;
      for (int k = 0; k < RD_LATENCY; k++) begin
         w_busy = w_busy | (|r_pipe_ch[k]);
      end
   end

   assign rvalid = r_pipe_ch[RD_LATENCY-1];
   assign rdata  = r_pipe_d[RD_LATENCY-1];
   assign busy   = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_mem_channel_interface.sv
//==============================================================================
// Module      : tb_mem_channel_interface
// Description : Self-checking bench for mem_channel_interface. A queue-based
//               model of requesters, round-robin arbitration, storage and the
//               read return schedule predicts gnt/rvalid/rdata/busy each cycle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_channel_interface;

   localparam int NCH = 2;
   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int NW  = 128;
   localparam int LAT = 3;
   localparam int SW  = DW / 8;

   logic               clk;
   logic               rst_n;
   logic [NCH-1:0]     req;
   logic [NCH-1:0]     we;
   logic [NCH*AW-1:0]  addr;
   logic [NCH*DW-1:0]  wdata;
   logic [NCH*SW-1:0]  wstrb;
   logic [NCH-1:0]     gnt;
   logic [NCH-1:0]     rvalid;
   logic [DW-1:0]      rdata;
   logic               busy;

   mem_channel_interface #(
      .NUM_CH     (NCH),
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .NUM_WORDS  (NW),
      .RD_LATENCY (LAT)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req),
      .we     (we),
      .addr   (addr),
      .wdata  (wdata),
      .wstrb  (wstrb),
      .gnt    (gnt),
      .rvalid (rvalid),
      .rdata  (rdata),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Requester state: a request stays pending until the model grants it.
   bit            p_req   [NCH];
   bit            p_we    [NCH];
   logic [AW-1:0] p_addr  [NCH];
   logic [DW-1:0] p_wdata [NCH];
   logic [SW-1:0] p_wstrb [NCH];

   // Model state.
   typedef struct {
      int          acc;
      int          due;
      int          ch;
      logic [DW-1:0] d;
   } rd_t;

   logic [DW-1:0] m_mem [NW];
   rd_t           q [$];
   int            m_ptr;
   int            edge_n;
   logic [DW-1:0] m_rdata;

   int            n_chk;
   int            n_pass;

   logic [NCH-1:0] s_gnt;
   logic [NCH-1:0] s_rvalid;
   logic [DW-1:0]  s_rdata;
   logic           s_busy;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   task automatic pend(input int ch, input bit w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [SW-1:0] s);
      p_req[ch]   = 1'b1;
      p_we[ch]    = w;
      p_addr[ch]  = a;
      p_wdata[ch] = d;
      p_wstrb[ch] = s;
   endtask

   task automatic drive();
      for (int ch = 0; ch < NCH; ch++) begin
         req[ch]                = p_req[ch];
         we[ch]                 = p_we[ch];
         addr[ch*AW +: AW]      = p_addr[ch];
         wdata[ch*DW +: DW]     = p_wdata[ch];
         wstrb[ch*SW +: SW]     = p_wstrb[ch];
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_ptr   = 0;
      m_rdata = '0;
   endtask

   // Reads due on this edge complete; busy covers reads accepted but not yet
   // past their completion cycle.
   task automatic compare_outputs();
      logic [NCH-1:0] erv;
      logic           eb;
      erv = '0;
      eb  = 1'b0;
      foreach (q[i]) begin
         if (q[i].due == edge_n) begin
            erv[q[i].ch] = 1'b1;
            m_rdata      = q[i].d;
         end
         if (q[i].acc <= edge_n && edge_n <= q[i].due) eb = 1'b1;
      end
      while (q.size() > 0 && q[0].due <= edge_n) q.delete(0);
      s_rvalid = rvalid;
      s_rdata  = rdata;
      s_busy   = busy;
      check("rvalid", rvalid, erv);
      check("rdata", rdata, m_rdata);
      check("busy", busy, eb);
   endtask

   // One clock: called at a negedge, returns at the next negedge.
   task automatic cycle();
      int g;
      int w;
      drive();
      #1;
      g = -1;
      for (int k = 0; k < NCH; k++) begin
         if (g < 0 && p_req[(m_ptr + k) % NCH]) g = (m_ptr + k) % NCH;
      end
      s_gnt = gnt;
      check("gnt", gnt, (g >= 0) ? (64'd1 << g) : 64'd0);
      @(posedge clk);
      edge_n++;
      if (g >= 0) begin
         w = int'((p_addr[g] >> 2) % NW);
         if (p_we[g]) begin
`ifdef MEMIF_BYTE_STROBE_EN
            for (int b = 0; b < SW; b++)
               if (p_wstrb[g][b]) m_mem[w][b*8 +: 8] = p_wdata[g][b*8 +: 8];
`else
            m_mem[w] = p_wdata[g];
`endif
         end else begin
            q.push_back('{acc: edge_n, due: edge_n + LAT - 1, ch: g, d: m_mem[w]});
         end
         p_req[g] = 1'b0;
         m_ptr    = (g + 1) % NCH;
      end
      #1;
      compare_outputs();
      @(negedge clk);
   endtask

   // Single read with nothing else pending; pins the returned value literally.
   task automatic read_lit(input int ch, input logic [AW-1:0] a,
                           input logic [DW-1:0] exp, input string nm);
      pend(ch, 1'b0, a, '0, '0);
      cycle();
      repeat (LAT - 1) cycle();
      check({nm, "_rv"}, s_rvalid, 64'd1 << ch);
      check({nm, "_rd"}, s_rdata, exp);
   endtask

   logic [NCH-1:0] seq [4];
   logic [NCH-1:0] rv3 [3];
   logic [DW-1:0]  rd3 [3];
   logic           bz  [5];
   logic [DW-1:0]  strobe_exp;

   initial begin
      n_chk  = 0;
      n_pass = 0;
      edge_n = 0;
      for (int ch = 0; ch < NCH; ch++) begin
         p_req[ch] = 1'b0; p_we[ch] = 1'b0; p_addr[ch] = '0;
         p_wdata[ch] = '0; p_wstrb[ch] = '0;
      end
      for (int i = 0; i < NW; i++) m_mem[i] = '0;
      model_reset();
      rst_n = 1'b0;
      drive();
      #2;
      check("rst_rvalid", rvalid, 0);
      check("rst_rdata", rdata, 0);
      check("rst_busy", busy, 0);
      // Both channels request while in reset: no grant may appear.
      pend(0, 1'b1, 32'h100, 32'h0000_1000, '1);
      pend(1, 1'b1, 32'h104, 32'h0000_1001, '1);
      drive();
      #1;
      check("rst_gnt", gnt, 0);
      @(posedge clk);
      #1;
      check("rst_rvalid2", rvalid, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // req=11 held four cycles after reset: strict alternation from ch0.
      for (int i = 0; i < 4; i++) begin
         for (int ch = 0; ch < NCH; ch++)
            if (!p_req[ch]) pend(ch, 1'b1, 32'h108 + 4*i + ch, 32'h2000 + i, '1);
         cycle();
         seq[i] = s_gnt;
      end
      check("rr_seq0", seq[0], 2'b01);
      check("rr_seq1", seq[1], 2'b10);
      check("rr_seq2", seq[2], 2'b01);
      check("rr_seq3", seq[3], 2'b10);
      repeat (2) cycle();

      // Fill every word so later reads are fully predicted.
      for (int i = 0; i < NW; i++) begin
         pend(0, 1'b1, 4*i, $urandom, '1);
         cycle();
      end

      // Write then read-after-write on the next cycle.
      pend(0, 1'b1, 32'h10, 32'hDEADBEEF, '1);
      cycle();
      read_lit(0, 32'h10, 32'hDEADBEEF, "raw");

      // Back-to-back reads ch0, ch1, ch0 with latency 3.
      pend(0, 1'b1, 32'h20, 32'h0A0A_0A0A, '1); cycle();
      pend(0, 1'b1, 32'h24, 32'h0B0B_0B0B, '1); cycle();
      pend(0, 1'b1, 32'h28, 32'h0C0C_0C0C, '1); cycle();
      pend(0, 1'b0, 32'h20, '0, '0); cycle(); bz[0] = s_busy;
      pend(1, 1'b0, 32'h24, '0, '0); cycle(); bz[1] = s_busy;
      pend(0, 1'b0, 32'h28, '0, '0); cycle(); bz[2] = s_busy;
      rv3[0] = s_rvalid; rd3[0] = s_rdata;
      cycle(); bz[3] = s_busy; rv3[1] = s_rvalid; rd3[1] = s_rdata;
      cycle(); bz[4] = s_busy; rv3[2] = s_rvalid; rd3[2] = s_rdata;
      check("b2b_rv0", rv3[0], 2'b01);
      check("b2b_rv1", rv3[1], 2'b10);
      check("b2b_rv2", rv3[2], 2'b01);
      check("b2b_rd0", rd3[0], 32'h0A0A_0A0A);
      check("b2b_rd1", rd3[1], 32'h0B0B_0B0B);
      check("b2b_rd2", rd3[2], 32'h0C0C_0C0C);
      for (int i = 0; i < 5; i++) check("b2b_busy", bz[i], 1'b1);
      cycle();

      // Partial-strobe write.
      pend(0, 1'b1, 32'h30, 32'h1122_3344, 4'b1111); cycle();
      pend(1, 1'b1, 32'h30, 32'hAABB_CCDD, 4'b0101); cycle();
`ifdef MEMIF_BYTE_STROBE_EN
      strobe_exp = 32'h11BB_33DD;
`else
      strobe_exp = 32'hAABB_CCDD;
`endif
      read_lit(1, 32'h30, strobe_exp, "strobe");

      // Address wrap: 0x200 aliases word 0.
      pend(0, 1'b1, 32'h200, 32'hCAFE_F00D, '1); cycle();
      read_lit(0, 32'h000, 32'hCAFE_F00D, "wrap");

      // Reset one cycle after a read accept: the read must never return.
      pend(0, 1'b0, 32'h10, '0, '0);
      cycle();
      rst_n = 1'b0;
      model_reset();
      pend(1, 1'b0, 32'h10, '0, '0);
      drive();
      #1;
      check("mrst_rvalid", rvalid, 0);
      check("mrst_rdata", rdata, 0);
      check("mrst_busy", busy, 0);
      check("mrst_gnt", gnt, 0);
      repeat (LAT + 1) begin
         @(posedge clk);
         #1;
         check("mrst_rvalid_hold", rvalid, 0);
         check("mrst_gnt_hold", gnt, 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      pend(0, 1'b0, 32'h30, '0, '0);
      cycle();
      check("mrst_ptr", s_gnt, 2'b01);
      repeat (LAT + 1) cycle();
      read_lit(0, 32'h10, 32'hDEADBEEF, "retain");

      // Randomized traffic on both channels, addresses spanning the wrap.
      for (int i = 0; i < 400; i++) begin
         for (int ch = 0; ch < NCH; ch++) begin
            if (!p_req[ch] && ($urandom_range(0, 99) < 60)) begin
               pend(ch, 1'($urandom_range(0, 1)),
                    AW'($urandom_range(0, 255) * 4 + $urandom_range(0, 3)),
                    $urandom, SW'($urandom_range(0, 15)));
            end
         end
         cycle();
      end
      repeat (LAT + 3) cycle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mem_channel_interface.md
MEM_CHANNEL_INTERFACE -- requirements
Module: mem_channel_interface

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning number of requester channels (1..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning word width in bits (multiple of 8).
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, meaning byte-address width.
REQ-004 SHALL have parameter NUM_WORDS, default 128, meaning storage depth in words (power of 2).
REQ-005 SHALL have parameter RD_LATENCY, default 1, meaning grant-to-rvalid cycles (1..4).
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port req  input  NUM_CH  per-channel access request.
REQ-009 SHALL have port we  input  NUM_CH  per-channel write enable (1 write, 0 read).
REQ-010 SHALL have port addr  input  NUM_CH*ADDR_WIDTH  per-channel byte address, channel i at slice i.
REQ-011 SHALL have port wdata  input  NUM_CH*DATA_WIDTH  per-channel write data.
REQ-012 SHALL have port wstrb  input  NUM_CH*DATA_WIDTH/8  per-channel byte write strobes.
REQ-013 SHALL have port gnt  output  NUM_CH  one-hot grant, combinational from req and arbiter pointer.
REQ-014 SHALL have port rvalid  output  NUM_CH  one-hot read-data-valid, registered.
REQ-015 SHALL have port rdata  output  DATA_WIDTH  shared read data, registered.
REQ-016 SHALL have port busy  output  1  high while any read is in flight in the pipeline.

Function
REQ-017 SHALL grant at most one channel per cycle; gnt[i] only when req[i] high; a request is accepted on the rising edge where gnt[i] is high.
REQ-018 SHALL arbitrate round-robin: search starts at pointer, ascending with wrap; pointer becomes granted index+1 (mod NUM_CH) after each accepted grant, unchanged when no grant.
REQ-019 SHALL require the requester to hold req/we/addr/wdata/wstrb stable until granted; ungranted requests are not lost.
REQ-020 SHALL compute word index = (addr >> 2) mod NUM_WORDS; upper address bits ignored (wrap-around).
REQ-021 SHALL commit a granted write to storage on the accepting edge; no rvalid for writes.
REQ-022 SHALL present a granted read's data on rdata with rvalid[i] high exactly RD_LATENCY cycles after the accepting edge, for one cycle.
REQ-023 SHALL sustain one accepted access per cycle (fully pipelined reads, back-to-back from any mix of channels).
REQ-024 SHALL return newly written data for a read accepted on any edge after the write's accepting edge (no stale read-after-write).
REQ-025 SHALL hold rdata at last value and rvalid at 0 when no read completes.
REQ-026 SHALL drive busy high whenever any pipeline stage holds a valid read.

Reset
REQ-027 SHALL, on rst_n low, immediately force rvalid=0, rdata=0, busy=0, arbiter pointer=0, and flush all in-flight reads.
REQ-028 SHALL never deliver rvalid for a read accepted before or during reset.
REQ-029 SHALL not clear storage contents on reset.
REQ-030 SHALL suppress gnt while rst_n is low.

Configuration
REQ-031 SHALL, with macro MEMIF_BYTE_STROBE_EN defined, update only bytes whose wstrb bit is 1 on a granted write (all-zero wstrb leaves the word unchanged).
REQ-032 SHALL, without MEMIF_BYTE_STROBE_EN, ignore wstrb and write the full word.

Verification
REQ-033 SHALL cover: ch0 write addr 0x10 data 0xDEADBEEF, next cycle ch0 read 0x10 -> rvalid[0] RD_LATENCY cycles later, rdata=0xDEADBEEF.
REQ-034 SHALL cover: req=2'b11 held 4 cycles after reset -> gnt sequence 01,10,01,10.
REQ-035 SHALL cover: RD_LATENCY=3, reads from ch0,ch1,ch0 on consecutive cycles -> rvalid 01,10,01 on three consecutive cycles, busy high throughout, data in order.
REQ-036 SHALL cover: MEMIF_BYTE_STROBE_EN, word 0x11223344, write 0xAABBCCDD wstrb 4'b0101 -> read 0x11BB33DD; without macro -> 0xAABBCCDD.
REQ-037 SHALL cover: rst_n asserted one cycle after a read accept -> rvalid stays 0, rdata=0, pointer=0; storage retains prior writes.
REQ-038 SHALL cover: NUM_WORDS=128, write addr 0x200 -> read addr 0x000 returns same data (wrap).
